core_exu_lsu: RTL
=================

# core_exu_lsu

Load/store unit for the RV32 core's execute stage. It consumes the effective address produced by the execute adder (rs1 + imm for load/store opcodes) together with funct3 and rs2 data. It runs one data-memory transaction per request over a valid/ready bus, and returns the aligned, sign- or zero-extended load result or store completion to writeback. It holds one outstanding access at a time and reports busy to the pipeline control.

## Interface
Parameters:
- none. Width is fixed at 32-bit address and data.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lsu_start`  in  1  one-cycle request strobe; sampled only in IDLE.
- `lsu_we`  in  1  1 = store, 0 = load.
- `lsu_funct3`  in  3  RV32 size/sign field (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `lsu_addr`  in  32  effective byte address from the execute adder.
- `lsu_wdata`  in  32  rs2 store data.
- `lsu_busy`  out  1  high from the cycle after an accepted start through DONE.
- `lsu_done`  out  1  one-cycle completion pulse.
- `lsu_rdata`  out  32  extended load result; valid while `lsu_done`.
- `lsu_err`  out  1  misaligned or illegal funct3; valid while `lsu_done`.
- `mem_req_valid`  out  1  bus request valid.
- `mem_req_ready`  in  1  bus accepts request.
- `mem_we`  out  1  bus write enable.
- `mem_addr`  out  32  word-aligned address; `addr[1:0]` = 0.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wstrb`  out  4  byte strobes; 0 for loads.
- `mem_rsp_valid`  in  1  load data valid.
- `mem_rdata`  in  32  load data word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE --start--> REQ. The request is latched: op, funct3, `addr[1:0]`, word address, wdata, strobes.
  - REQ --valid&ready, store--> DONE.
  - REQ --valid&ready, load--> WAIT.
  - WAIT --rsp_valid--> DONE. `mem_rdata` is captured, extracted and extended.
  - DONE --> IDLE unconditionally.
- `lsu_start` in any state other than IDLE is ignored; no queuing.
- Store lanes:
  - SB: byte replicated ×4, strobe = 1 << `addr[1:0]`.
  - SH: halfword replicated ×2, strobe 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - SW: strobe 1111.
- Load extract:
  - Byte selected by `addr[1:0]`; halfword selected by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Illegal funct3 (load 011/110/111, store 1xx/011): no bus access; completes through DONE with `lsu_err`=1 and `lsu_rdata`=0.
- `mem_rsp_valid` outside WAIT is ignored.

## Timing
- All outputs reset to 0, and the state resets to IDLE.
- `mem_*` outputs are registered. `mem_req_valid` stays high and bus fields stay stable until ready.
- Store with ready already high: start in c0, REQ handshake in c1, `lsu_done` in c2.
- Load with zero-wait response: start in c0, REQ in c1, rsp in c2, `lsu_done`+`lsu_rdata` in c3.
- Each cycle ready is low adds one cycle in REQ. Each cycle without a response adds one cycle in WAIT.
- Error completion: start in c0, DONE in c1.
- `lsu_done` is never high for two consecutive cycles. The earliest next start is the cycle after DONE.
- Reset asserted mid-transaction returns the FSM to IDLE and drops `mem_req_valid` immediately. The bus side tolerates an abandoned request. A late response after reset is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Half access with `addr[0]`=1, or word access with `addr[1:0]`≠0, goes directly to DONE with `lsu_err`=1.
  - No bus request is issued.
- Not defined:
  - No misalignment check. Low address bits are forced to alignment: half uses `addr[1]` with `addr[0]` ignored; word ignores `addr[1:0]`.
  - `lsu_err` reports illegal funct3 only.

## Structure
- Opcode/funct3 constants (`load`, `store`, LB…SW encodings) and the 2-bit FSM state localparams go in the shared `inst_define.v`.
- Sub-module `core_lsu_align`: combinational.
  - Store side: strobe and data replication.
  - Load side: lane extract and sign/zero extension.
- The top level holds the FSM, the request registers and bus handshaking.

## Test plan
- SW to addr 0x1000, data 0xDEADBEEF, ready=1:
  - `mem_addr`=0x1000, strobe 1111.
  - `lsu_done` two cycles after start.
- SB to addr 0x1003, data 0x000000A5:
  - `mem_wdata`=0xA5A5A5A5, strobe 1000.
- LB at 0x2002, `mem_rdata`=0x12805634, 2-cycle response delay:
  - `lsu_rdata`=0xFFFFFF80.
  - LBU at the same address and data gives 0x00000080.
  - Done arrives 5 cycles after start.
- REQ with ready held low for 3 cycles:
  - valid and fields stay stable.
  - A second `lsu_start` during this stall is ignored.
- LW at 0x3002:
  - With `LSU_MISALIGN_TRAP_EN`: done at c1, `lsu_err`=1, no valid.
  - Without it: `mem_addr`=0x3000, `lsu_err`=0.
- `rst_n` low while in WAIT:
  - Outputs go to 0 immediately.
  - A subsequent `mem_rsp_valid` produces no `lsu_done`.

Source files
------------

// File: rtl/core_exu_lsu_pkg.sv
// Shared definitions for the execute-stage load/store unit: FSM state
// encoding, RV32 load/store funct3 encodings and a funct3 legality helper.
package core_exu_lsu_pkg;

    // Transaction FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // funct3 size/sign encodings shared by loads (LB..LHU) and stores (SB..SW)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores accept B/H/W only; loads additionally accept the unsigned forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane logic for the load/store unit.
// Store side: byte/half replication across the bus word and byte strobes,
// plus illegal-funct3 and misalignment classification of the request.
// Load side: lane extraction from the returned word and sign/zero extension.
module core_lsu_align
    import core_exu_lsu_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_wdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic        req_illegal,
    output logic        req_misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte [4];
    logic [7:0]  ld_byte_sel;
    logic [15:0] ld_half_sel;

    // Split the returned word into its four byte lanes
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign ld_byte[gi] = ld_word[8*gi +: 8];
    end

    // Store replication and strobes; loads never drive strobes
    always_comb begin
        st_wdata = req_wdata;
        st_wstrb = 4'b0000;
        case (req_funct3)
            F3_B: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr_lo;
            end
            F3_H: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
                st_wstrb = 4'b1111;
            end
            default: begin
                st_wstrb = 4'b0000;
            end
        endcase
        if (!req_we) begin
            st_wstrb = 4'b0000;
        end
    end

    // Request classification: illegal size/sign field and natural alignment
    always_comb begin
        req_illegal    = ~f3_legal(req_we, req_funct3);
        req_misaligned = 1'b0;
        case (req_funct3)
            F3_H, F3_HU: req_misaligned = req_addr_lo[0];
            F3_W:        req_misaligned = |req_addr_lo;
            default:     req_misaligned = 1'b0;
        endcase
    end

    // Load lane select and extension; half uses addr[1] only, word ignores both bits
    always_comb begin
        ld_byte_sel = ld_byte[ld_addr_lo];
        ld_half_sel = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte_sel[7]}}, ld_byte_sel};
            F3_BU:   ld_data = {24'h000000, ld_byte_sel};
            F3_H:    ld_data = {{16{ld_half_sel[15]}}, ld_half_sel};
            F3_HU:   ld_data = {16'h0000, ld_half_sel};
            F3_W:    ld_data = ld_word;
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/core_exu_lsu.sv
// RV32 execute-stage load/store unit. One outstanding data-memory access at a
// time over a valid/ready request bus with a separate load-response strobe.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half
// and word accesses complete with lsu_err and never reach the bus; otherwise
// the low address bits are ignored as needed to force alignment.
module core_exu_lsu
    import core_exu_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_start,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_reg;
    lsu_state_t  state_next;

    logic        req_we_reg;
    logic [2:0]  req_funct3_reg;
    logic [1:0]  req_addr_lo_reg;
    logic        mem_req_valid_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [3:0]  mem_wstrb_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic        req_illegal;
    logic        req_misaligned;
    logic [31:0] ld_data;

    logic        req_reject;
    logic        accept;
    logic        bus_fire;
    logic        rsp_fire;

    core_lsu_align u_align (
        .req_we         (lsu_we),
        .req_funct3     (lsu_funct3),
        .req_addr_lo    (lsu_addr[1:0]),
        .req_wdata      (lsu_wdata),
        .st_wdata       (st_wdata),
        .st_wstrb       (st_wstrb),
        .req_illegal    (req_illegal),
        .req_misaligned (req_misaligned),
        .ld_funct3      (req_funct3_reg),
        .ld_addr_lo     (req_addr_lo_reg),
        .ld_word        (mem_rdata),
        .ld_data        (ld_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_reject = req_illegal | req_misaligned;
`else
    // Misalignment is tolerated: the lane logic simply ignores the low bits.
    logic unused_misaligned;
    assign unused_misaligned = req_misaligned;
    assign req_reject        = req_illegal;
`endif

    assign accept   = (state_reg == ST_IDLE) & lsu_start;
    assign bus_fire = (state_reg == ST_REQ) & mem_req_valid_reg & mem_req_ready;
    assign rsp_fire = (state_reg == ST_WAIT) & mem_rsp_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: rejected requests skip the bus and finish straight away
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = req_reject ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_fire) begin
                    state_next = req_we_reg ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_fire) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, registered bus fields and load result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_reg        <= 1'b0;
            req_funct3_reg    <= 3'b000;
            req_addr_lo_reg   <= 2'b00;
            mem_req_valid_reg <= 1'b0;
            mem_we_reg        <= 1'b0;
            mem_addr_reg      <= 32'h0000_0000;
            mem_wdata_reg     <= 32'h0000_0000;
            mem_wstrb_reg     <= 4'b0000;
            rdata_reg         <= 32'h0000_0000;
            err_reg           <= 1'b0;
        end else begin
            if (accept) begin
                req_we_reg        <= lsu_we;
                req_funct3_reg    <= lsu_funct3;
                req_addr_lo_reg   <= lsu_addr[1:0];
                mem_req_valid_reg <= ~req_reject;
                mem_we_reg        <= lsu_we;
                mem_addr_reg      <= {lsu_addr[31:2], 2'b00};
                mem_wdata_reg     <= lsu_we ? st_wdata : 32'h0000_0000;
                mem_wstrb_reg     <= st_wstrb;
                rdata_reg         <= 32'h0000_0000;
                err_reg           <= req_reject;
            end
            if (bus_fire) begin
                mem_req_valid_reg <= 1'b0;
            end
            if (rsp_fire) begin
                rdata_reg <= ld_data;
            end
        end
    end

    // Pipeline-facing outputs; result and error are only presented during DONE
    always_comb begin
        lsu_busy  = (state_reg != ST_IDLE);
        lsu_done  = (state_reg == ST_DONE);
        lsu_rdata = lsu_done ? rdata_reg : 32'h0000_0000;
        lsu_err   = lsu_done & err_reg;
    end

    assign mem_req_valid = mem_req_valid_reg;
    assign mem_we        = mem_we_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_wdata     = mem_wdata_reg;
    assign mem_wstrb     = mem_wstrb_reg;

endmodule
